// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide unit for the EX stage
//
// Shift-add multiply and restoring divide, one iteration per clock, with a
// single-cycle done pulse and a combinational stall that holds the pipeline.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, operations with a==0, b==0 or signed-division overflow skip
//   the iteration phase and resolve in FIX. The results are identical.
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   start   in   M-extension instruction present in EX (level, held while stalled)
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   src_a   in   rs1 operand (multiplicand / dividend)
//   src_b   in   rs2 operand (multiplier / divisor)
//   flush   in   abandon any in-flight operation
//   stall   out  freeze IF/ID/EX (combinational)
//   busy    out  registered, high outside IDLE
//   done    out  registered, one-cycle pulse with a valid result
//   result  out  registered, last completed value
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic [2:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic               a_zero;
    logic               b_zero;
    logic               ovf;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    // Operand decode, only consumed in IDLE
    logic             a_signed_in;
    logic             b_signed_in;
    logic             neg_a_in;
    logic             neg_b_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             a_zero_in;
    logic             b_zero_in;
    logic             ovf_in;

    // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned
    assign a_signed_in = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
    assign b_signed_in = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
    assign neg_a_in    = a_signed_in & src_a[WIDTH-1];
    assign neg_b_in    = b_signed_in & src_b[WIDTH-1];
    assign mag_a_in    = neg_a_in ? -src_a : src_a;
    assign mag_b_in    = neg_b_in ? -src_b : src_b;
    assign a_zero_in   = (src_a == '0);
    assign b_zero_in   = (src_b == '0);
    assign ovf_in      = funct3[2] & ~funct3[0] & (src_a == MIN_NEG) & (src_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    logic early_in;
    assign early_in = a_zero_in | b_zero_in | ovf_in;
`endif

    // Multiply step: the low half of prod holds the not-yet-consumed multiplier
    // bits; add |a| into the high half when the current bit is set, then shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // Divide step: the trial remainder is WIDTH+1 bits wide; when the subtract
    // succeeds the difference is below |b| and fits back in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, mag_b});
    assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

    // Sign fix-up and special cases. The zero/overflow overrides keep the
    // early-out path correct even though prod/quo/rem were never iterated.
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   a_val;
    logic [WIDTH-1:0]   fix_val;

    assign neg_res = sign_a ^ sign_b;
    assign prod_s  = neg_res ? -prod : prod;
    assign quo_s   = neg_res ? -quo : quo;
    assign rem_s   = sign_a ? -rem : rem;
    assign a_val   = sign_a ? -mag_a : mag_a;

    always_comb begin
        fix_val = '0;
        case (op)
            3'b000:                 fix_val = (a_zero | b_zero) ? '0 : prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = (a_zero | b_zero) ? '0 : prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (b_zero)      fix_val = '1;
                else if (ovf)    fix_val = a_val;
                else if (a_zero) fix_val = '0;
                else             fix_val = quo_s;
            end
            default: begin
                if (b_zero)               fix_val = a_val;
                else if (ovf | a_zero)    fix_val = '0;
                else                      fix_val = rem_s;
            end
        endcase
    end

    assign stall = ((state == S_IDLE) & start) | (state == S_CALC) | (state == S_FIX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_zero <= 1'b0;
            b_zero <= 1'b0;
            ovf    <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            count  <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op     <= funct3;
                            sign_a <= neg_a_in;
                            sign_b <= neg_b_in;
                            a_zero <= a_zero_in;
                            b_zero <= b_zero_in;
                            ovf    <= ovf_in;
                            mag_a  <= mag_a_in;
                            mag_b  <= mag_b_in;
                            count  <= CW'(WIDTH - 1);
                            prod   <= {{WIDTH{1'b0}}, mag_b_in};
                            rem    <= '0;
                            quo    <= mag_a_in;
                            busy   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                            state  <= early_in ? S_FIX : S_CALC;
`else
                            state  <= S_CALC;
`endif
                        end
                    end
                    S_CALC: begin
                        if (op[2]) begin
                            rem <= div_ok ? div_sub : div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], div_ok};
                        end else begin
                            prod <= mul_next;
                        end
                        count <= count - 1'b1;
                        if (count == '0) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors;
    int checks;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0 || (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation starting in the current (IDLE) cycle and reports
    // what was observed; returns one cycle after the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [31:0] res, output int lat,
                          output bit stall_ok, output bit tail_ok);
        funct3 = f;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        lat = -1;
        res = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                res = result;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (scramble) begin
                src_a  = $urandom;
                src_b  = $urandom;
                funct3 = 3'($urandom);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        tail_ok = (done === 1'b0) && (busy === 1'b0) && (result === res);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'd0;
        src_a   = 32'd0;
        src_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h stall=%b, want 0 0 00000000 0",
                     busy, done, result, stall);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_table(input string name, input logic [2:0] fs[], input logic [31:0] as[],
                              input logic [31:0] bs[]);
        logic [31:0] res;
        logic [31:0] want;
        int          lat;
        bit          s_ok;
        bit          t_ok;
        for (int i = 0; i < fs.size(); i++) begin
            run_op(fs[i], as[i], bs[i], 1'b0, res, lat, s_ok, t_ok);
            want = ref_model(fs[i], as[i], bs[i]);
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL %s_result[%0d] f=%0d a=%h b=%h: got %h want %h", name, i, fs[i], as[i], bs[i], res, want);
            end
            checks++;
            if (lat !== exp_lat(fs[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, exp_lat(fs[i], as[i], bs[i]));
            end
            checks++;
            if (s_ok !== 1'b1 || t_ok !== 1'b1) begin
                errors++;
                $display("FAIL %s_handshake[%0d]: stall_ok=%b tail_ok=%b want 1 1", name, i, s_ok, t_ok);
            end
        end
    endtask

    task automatic test_mul();
        test_table("mul", '{3'd0, 3'd1, 3'd3, 3'd2},
                   '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                   '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        checks++;
        if (result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_const: got %h want ffffffff", result);
        end
    endtask

    task automatic test_div();
        test_table("div", '{3'd4, 3'd6, 3'd5, 3'd7},
                   '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
                   '{32'd2, 32'd2, 32'd7, 32'd7});
        checks++;
        if (result !== 32'd2) begin
            errors++;
            $display("FAIL remu_const: got %h want 00000002", result);
        end
    endtask

    task automatic test_corner();
        test_table("corner", '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd0},
                   '{32'd5, 32'hDEAD_BEEF, 32'd5, 32'hFFFF_FFF0, 32'h8000_0000, 32'h8000_0000,
                     32'd0, 32'h1234_5678, 32'd0, 32'h8000_0000},
                   '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'd99, 32'd0, 32'd5, 32'hFFFF_FFFF});
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        bit          s_ok;
        bit          t_ok;
        int          seen;
        run_op(3'd5, 32'd100, 32'd7, 1'b0, res, lat, s_ok, t_ok);
        funct3 = 3'd4;
        src_a  = 32'hFFFF_FFF9;
        src_b  = 32'd2;
        start  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
            errors++;
            $display("FAIL flush_idle: busy=%b done=%b result=%h want 0 0 0000000e", busy, done, result);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_resume: active cycles=%0d want 0", seen);
        end
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_start: busy=%b want 0", busy);
        end
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd3, 32'd4, 1'b0, res, lat, s_ok, t_ok);
        checks++;
        if (res !== 32'd12 || lat !== 34) begin
            errors++;
            $display("FAIL mul_after_flush: result=%h lat=%0d want 0000000c 34", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        funct3 = 3'd0;
        src_a  = 32'd5;
        src_b  = 32'd6;
        start  = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_resume: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          s_ok;
        bit          t_ok;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            run_op(3'd5, a, b, 1'b1, res, lat, s_ok, t_ok);
            checks++;
            if (res !== a / b || lat !== 34 || t_ok !== 1'b1) begin
                errors++;
                $display("FAIL b2b_divu[%0d] a=%h b=%h: result=%h lat=%0d tail=%b want %h 34 1",
                         i, a, b, res, lat, t_ok, a / b);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        logic [2:0]  f;
        int          lat;
        bit          s_ok;
        bit          t_ok;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, 1'($urandom), res, lat, s_ok, t_ok);
            want = ref_model(f, a, b);
            checks++;
            if (res !== want || lat !== exp_lat(f, a, b) || s_ok !== 1'b1 || t_ok !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: result=%h lat=%0d stall=%b tail=%b want %h %0d 1 1",
                         i, f, a, b, res, lat, s_ok, t_ok, want, exp_lat(f, a, b));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mul();
        test_div();
        test_corner();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
